vga_frame_sync: RTL and testbench
=================================

# vga_frame_sync

Frame-synchronous snapshot and halt controller between the matching engine and `vga_display`. It accepts best-bid/best-ask updates and trade pulses through a valid/ready interface into shadow registers. Once per frame, at the start of vertical blanking, it copies them into the registered `buy_price`/`sell_price`/`trade_count`/`spread` display inputs, so a frame never tears. It also owns `halt_signal`, entering halt on a crossed book or on a sustained wide spread, and leaving halt only on an operator resume.

## Interface
- `SPREAD_LIMIT`, 8'd40: spread strictly above this counts as a wide frame.
- `HALT_FRAMES`, 4'd3: consecutive wide snapshots that trigger halt; legal range 1..15.
- `V_SNAP`, 10'd480: `v_cnt` value of the snapshot point (first blanking line).
- `H_SNAP`, 10'd0: `h_cnt` value of the snapshot point.
- `clk_25mhz`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `h_cnt`  in  10  horizontal counter from the sync generator.
- `v_cnt`  in  10  vertical counter from the sync generator.
- `upd_valid`  in  1  price update offered.
- `upd_buy`  in  8  best bid carried by the update.
- `upd_sell`  in  8  best ask carried by the update.
- `upd_ready`  out  1  block accepts the update this cycle.
- `trade_pulse`  in  1  one executed trade, counted each cycle it is high.
- `resume`  in  1  single-cycle operator pulse that clears halt.
- `buy_price`  out  8  registered bid shown this frame.
- `sell_price`  out  8  registered ask shown this frame.
- `trade_count`  out  8  trades executed in the previous frame (saturating).
- `spread`  out  8  registered `sell_price - buy_price`; 0 if the book is crossed.
- `halt_signal`  out  1  trading halted; display is frozen.
- `frame_tick`  out  1  one-cycle pulse marking each snapshot that loads the display registers.

## Operation
- A snapshot point (`snap`) occurs when `h_cnt==H_SNAP && v_cnt==V_SNAP`.
- Shadow path:
  - `upd_ready` is 1 in every cycle except the `snap` cycle.
  - On `upd_valid && upd_ready`, `shadow_buy`/`shadow_sell` load `upd_buy`/`upd_sell`.
  - A `trade_pulse` increments `shadow_trades`, which saturates at 255.
- The state machine has two states, RUN and HALTED.
- RUN, on a `snap` cycle:
  - Copy the shadow prices to `buy_price`/`sell_price`.
  - Copy `shadow_trades` to `trade_count`. Reset `shadow_trades` to 0, or to 1 if `trade_pulse` is high in the same cycle.
  - Compute `d = shadow_sell - shadow_buy` at 9 bits. `spread` = d[7:0] if `shadow_sell >= shadow_buy`, else 0.
  - Pulse `frame_tick`.
- Halt conditions, evaluated on the RUN `snap` cycle from the shadow values:
  - Crossed book (`shadow_sell < shadow_buy`) halts immediately.
  - Otherwise, if the new `spread > SPREAD_LIMIT`, the 4-bit `streak` increments; else `streak` clears to 0.
  - When `streak` reaches `HALT_FRAMES`, the block halts.
  - On a halting snapshot, the offending values are still loaded into the display registers and `frame_tick` still pulses.
  - The transition is to HALTED with `halt_signal` = 1.
- HALTED:
  - Display registers hold their values and `snap` produces no `frame_tick`.
  - The shadow path keeps running; `shadow_trades` keeps counting and saturates.
  - `resume` moves the block to RUN with `halt_signal` = 0 and `streak` = 0.
  - The first snapshot after resume reloads every display register.
- `resume` while in RUN has no effect.

## Timing
- Reset (`rst_n`=0, async) sets:
  - every output to 0, including `upd_ready`;
  - shadows, `streak` and `shadow_trades` to 0;
  - state to RUN.
- `upd_ready` rises on the first clock edge after `rst_n` deasserts.
- Shadow load has one-cycle latency. An update accepted in cycle N is visible in `shadow_*` in cycle N+1.
- Display registers and `frame_tick` update on the edge that closes the `snap` cycle.
- An update offered during `snap` stalls, because `upd_ready`=0. It is accepted in the next cycle and lands in the following frame.
- `halt_signal` rises on the same edge as its triggering snapshot's display load.
- `resume` in cycle N: `halt_signal` falls at the edge ending N.
- `resume` in the same cycle as a RUN `snap` is ignored; the snapshot proceeds normally.
- Reset mid-frame: all state clears. The first snapshot after reset loads whatever was accepted since the reset.

## Test plan
- Reset, then accept buy=100 and sell=120 mid-frame, then reach v=480/h=0 → display shows buy=100, sell=120, spread=20, `frame_tick` for 1 cycle, halt=0.
- Offer `upd_valid` exactly on the `snap` cycle with 50/60, old shadow 10/20 → `upd_ready`=0 that cycle; display shows 10/20; next frame shows 50/60.
- Hold `trade_pulse` high for 300 cycles in one frame → `trade_count`=255. With no pulses in the next frame → `trade_count`=0.
- Run 3 frames with spread 41, then resume, with `SPREAD_LIMIT`=40 and `HALT_FRAMES`=3 → halt rises at the 3rd snapshot with spread=41 displayed; frozen across 2 further snapshots with no `frame_tick`; `resume` clears halt; next snapshot reloads.
- Load buy=90, sell=80 (crossed book) → first snapshot: spread=0, halt=1; a streak of 2 wide frames followed by 1 frame at spread 40 → no halt, `streak` cleared.
- Assert `rst_n`=0 while halted and mid-frame → all outputs 0 immediately; `upd_ready`=1 after the first edge following release.

Source files
------------

// File: rtl/vga_frame_sync_if.sv
// Price-update handshake between the matching engine and vga_frame_sync.
interface vga_frame_sync_if;
  logic       upd_valid;
  logic [7:0] upd_buy;
  logic [7:0] upd_sell;
  logic       upd_ready;

  modport master (output upd_valid, upd_buy, upd_sell, input upd_ready);
  modport slave  (input upd_valid, upd_buy, upd_sell, output upd_ready);
endinterface

// File: rtl/vga_frame_sync.sv
// Frame-synchronous snapshot of book/trade data into the display registers,
// plus the trading-halt state machine (crossed book or sustained wide spread).
module vga_frame_sync #(
  parameter logic [7:0] SPREAD_LIMIT = 8'd40,
  parameter logic [3:0] HALT_FRAMES  = 4'd3,
  parameter logic [9:0] V_SNAP       = 10'd480,
  parameter logic [9:0] H_SNAP       = 10'd0
) (
  input  logic                    clk_25mhz,
  input  logic                    rst_n,
  input  logic [9:0]              h_cnt,
  input  logic [9:0]              v_cnt,
  vga_frame_sync_if.slave         upd,
  input  logic                    trade_pulse,
  input  logic                    resume,
  output logic [7:0]              buy_price,
  output logic [7:0]              sell_price,
  output logic [7:0]              trade_count,
  output logic [7:0]              spread,
  output logic                    halt_signal,
  output logic                    frame_tick
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       ready_q, ready_d;
  logic [7:0] shadow_buy_q, shadow_buy_d;
  logic [7:0] shadow_sell_q, shadow_sell_d;
  logic [7:0] shadow_trades_q, shadow_trades_d;
  logic [7:0] buy_price_q, buy_price_d;
  logic [7:0] sell_price_q, sell_price_d;
  logic [7:0] trade_count_q, trade_count_d;
  logic [7:0] spread_q, spread_d;
  logic       halt_q, halt_d;
  logic       frame_tick_q, frame_tick_d;

  logic       snap;
  logic       snap_run;
  logic       accept;
  logic [8:0] diff;
  logic       crossed;
  logic [7:0] spread_new;
  logic       wide;
  logic [3:0] streak_inc;

  assign snap     = (h_cnt == H_SNAP) && (v_cnt == V_SNAP);
  assign snap_run = snap && (state_q == RUN);

  // ready_q keeps upd_ready low through reset and until the first edge after it
  assign upd.upd_ready = ready_q & ~snap;
  assign accept        = upd.upd_valid & upd.upd_ready;

  assign diff       = {1'b0, shadow_sell_q} - {1'b0, shadow_buy_q};
  assign crossed    = diff[8];
  assign spread_new = crossed ? '0 : diff[7:0];
  assign wide       = spread_new > SPREAD_LIMIT;
  assign streak_inc = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;

  // State register
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    unique case (state_q)
      RUN: begin
        if (snap) begin
          if (crossed) begin
            state_d  = HALTED;
            streak_d = '0;
          end else if (wide) begin
            streak_d = streak_inc;
            if (streak_inc >= HALT_FRAMES) state_d = HALTED;
          end else begin
            streak_d = '0;
          end
        end
      end
      HALTED: begin
        if (resume) begin
          state_d  = RUN;
          streak_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic: display registers load only on a RUN snapshot
  always_comb begin
    buy_price_d   = buy_price_q;
    sell_price_d  = sell_price_q;
    trade_count_d = trade_count_q;
    spread_d      = spread_q;
    frame_tick_d  = snap_run;
    halt_d        = (state_d == HALTED);
    if (snap_run) begin
      buy_price_d   = shadow_buy_q;
      sell_price_d  = shadow_sell_q;
      trade_count_d = shadow_trades_q;
      spread_d      = spread_new;
    end
  end

  // Shadow path runs in both states; the trade counter restarts only on a RUN snapshot
  always_comb begin
    ready_d       = 1'b1;
    shadow_buy_d  = shadow_buy_q;
    shadow_sell_d = shadow_sell_q;
    if (accept) begin
      shadow_buy_d  = upd.upd_buy;
      shadow_sell_d = upd.upd_sell;
    end
    if (snap_run) begin
      shadow_trades_d = trade_pulse ? 8'd1 : 8'd0;
    end else if (trade_pulse && (shadow_trades_q != 8'hFF)) begin
      shadow_trades_d = shadow_trades_q + 8'd1;
    end else begin
      shadow_trades_d = shadow_trades_q;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      ready_q         <= 1'b0;
      shadow_buy_q    <= '0;
      shadow_sell_q   <= '0;
      shadow_trades_q <= '0;
      buy_price_q     <= '0;
      sell_price_q    <= '0;
      trade_count_q   <= '0;
      spread_q        <= '0;
      halt_q          <= 1'b0;
      frame_tick_q    <= 1'b0;
    end else begin
      ready_q         <= ready_d;
      shadow_buy_q    <= shadow_buy_d;
      shadow_sell_q   <= shadow_sell_d;
      shadow_trades_q <= shadow_trades_d;
      buy_price_q     <= buy_price_d;
      sell_price_q    <= sell_price_d;
      trade_count_q   <= trade_count_d;
      spread_q        <= spread_d;
      halt_q          <= halt_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign buy_price   = buy_price_q;
  assign sell_price  = sell_price_q;
  assign trade_count = trade_count_q;
  assign spread      = spread_q;
  assign halt_signal = halt_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_frame_sync.sv
// Bench for vga_frame_sync: directed vector table, hand sequences for the
// multi-cycle halt/trade/reset cases, and random traffic against a reference model.
module tb_vga_frame_sync;

  localparam int LIMIT = 40;
  localparam int HF    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] h_cnt = '0;
  logic [9:0] v_cnt = '0;
  logic       trade_pulse = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] buy_price, sell_price, trade_count, spread;
  logic       halt_signal, frame_tick;

  vga_frame_sync_if u_if ();

  vga_frame_sync #(
    .SPREAD_LIMIT(8'(LIMIT)),
    .HALT_FRAMES (4'(HF)),
    .V_SNAP      (10'd480),
    .H_SNAP      (10'd0)
  ) dut (
    .clk_25mhz  (clk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .upd        (u_if.slave),
    .trade_pulse(trade_pulse),
    .resume     (resume),
    .buy_price  (buy_price),
    .sell_price (sell_price),
    .trade_count(trade_count),
    .spread     (spread),
    .halt_signal(halt_signal),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers
  int m_ready, m_sbuy, m_ssell, m_strades;
  int m_buy, m_sell, m_tc, m_spread, m_tick, m_halted, m_streak;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_sbuy = 0; m_ssell = 0; m_strades = 0;
    m_buy = 0; m_sell = 0; m_tc = 0; m_spread = 0; m_tick = 0;
    m_halted = 0; m_streak = 0;
  endtask

  task automatic model_edge(input int h, input int v, input int uv, input int ub,
                            input int us, input int tp, input int res);
    bit snap_now;
    bit rdy;
    int d;
    snap_now = (h == 0) && (v == 480);
    rdy = (m_ready != 0) && !snap_now;
    if (!m_halted && snap_now) begin
      d = m_ssell - m_sbuy;
      m_buy = m_sbuy; m_sell = m_ssell; m_tc = m_strades;
      m_spread = (d < 0) ? 0 : d;
      m_strades = tp;
      m_tick = 1;
      if (d < 0) begin
        m_halted = 1; m_streak = 0;
      end else begin
        m_streak = (d > LIMIT) ? m_streak + 1 : 0;
        if (m_streak >= HF) m_halted = 1;
      end
    end else begin
      m_tick = 0;
      if (m_halted && res) begin
        m_halted = 0; m_streak = 0;
      end
      if (tp && m_strades < 255) m_strades++;
    end
    if (uv && rdy) begin
      m_sbuy = ub; m_ssell = us;
    end
    m_ready = 1;
  endtask

  task automatic check_outputs();
    chk("buy_price", buy_price, m_buy);
    chk("sell_price", sell_price, m_sell);
    chk("trade_count", trade_count, m_tc);
    chk("spread", spread, m_spread);
    chk("frame_tick", frame_tick, m_tick);
    chk("halt_signal", halt_signal, m_halted);
  endtask

  // Called at posedge+1; drives one cycle and checks ready before and outputs after the edge
  task automatic step(input int h, input int v, input int uv, input int ub,
                      input int us, input int tp, input int res);
    bit snap_now;
    h_cnt = 10'(h); v_cnt = 10'(v);
    u_if.upd_valid = uv[0]; u_if.upd_buy = 8'(ub); u_if.upd_sell = 8'(us);
    trade_pulse = tp[0]; resume = res[0];
    snap_now = (h == 0) && (v == 480);
    #2;
    chk("upd_ready", u_if.upd_ready, ((m_ready != 0) && !snap_now) ? 1 : 0);
    @(posedge clk);
    model_edge(h, v, uv, ub, us, tp, res);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1 + (i % 700), 100, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int b, input int s);
    step(5, 200, 1, b, s, 0, 0);
  endtask

  task automatic do_snap(input int tp, input int res);
    step(0, 480, 0, 0, 0, tp, res);
    step(1, 480, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, u_if.upd_ready, 0);
    chk({nm, "_buy"}, buy_price, 0);
    chk({nm, "_sell"}, sell_price, 0);
    chk({nm, "_tc"}, trade_count, 0);
    chk({nm, "_spread"}, spread, 0);
    chk({nm, "_halt"}, halt_signal, 0);
    chk({nm, "_tick"}, frame_tick, 0);
  endtask

  typedef struct {
    int h, v, uv, ub, us, tp;
    int rdy, eb, es, etc, esp, etick, ehalt;
  } vec_t;

  vec_t vec [8];

  initial begin
    // h, v, uv, ub, us, tp | ready, buy, sell, tc, spread, tick, halt
    vec[0] = '{5,  10,  1, 100, 120, 0, 1, 0,   0,   0, 0,  0, 0};
    vec[1] = '{0,  480, 0, 0,   0,   0, 0, 100, 120, 0, 20, 1, 0};
    vec[2] = '{1,  480, 0, 0,   0,   0, 1, 100, 120, 0, 20, 0, 0};
    vec[3] = '{5,  10,  1, 10,  20,  0, 1, 100, 120, 0, 20, 0, 0};
    vec[4] = '{0,  480, 1, 50,  60,  0, 0, 10,  20,  0, 10, 1, 0};
    vec[5] = '{1,  480, 1, 50,  60,  0, 1, 10,  20,  0, 10, 0, 0};
    vec[6] = '{0,  480, 0, 0,   0,   0, 0, 50,  60,  0, 10, 1, 0};
    vec[7] = '{2,  0,   0, 0,   0,   0, 1, 50,  60,  0, 10, 0, 0};

    u_if.upd_valid = 1'b0; u_if.upd_buy = '0; u_if.upd_sell = '0;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_after_release", u_if.upd_ready, 0);
    idle(1);

    // Directed table: mid-frame load, snapshot, stalled update on snap cycle
    for (int i = 0; i < 8; i++) begin
      #2;
      h_cnt = 10'(vec[i].h); v_cnt = 10'(vec[i].v);
      u_if.upd_valid = vec[i].uv[0];
      #0;
      chk("tbl_ready", u_if.upd_ready, vec[i].rdy);
      #(-2 + 2);
      step(vec[i].h, vec[i].v, vec[i].uv, vec[i].ub, vec[i].us, vec[i].tp, 0);
      chk("tbl_buy", buy_price, vec[i].eb);
      chk("tbl_sell", sell_price, vec[i].es);
      chk("tbl_tc", trade_count, vec[i].etc);
      chk("tbl_spread", spread, vec[i].esp);
      chk("tbl_tick", frame_tick, vec[i].etick);
      chk("tbl_halt", halt_signal, vec[i].ehalt);
      @(posedge clk); #1;
    end

    // Trade counter saturation, clear, and restart-at-1 on a pulsed snapshot
    for (int i = 0; i < 300; i++) step(1 + (i % 600), 300, 0, 0, 0, 1, 0);
    do_snap(0, 0);
    chk("trades_sat", trade_count, 255);
    idle(20);
    do_snap(1, 0);
    chk("trades_zero", trade_count, 0);
    idle(5);
    do_snap(0, 0);
    chk("trades_restart", trade_count, 1);

    // Sustained wide spread: halt on the third snapshot, freeze, resume, reload
    load(100, 141);
    for (int f = 0; f < 3; f++) begin
      idle(3);
      do_snap(0, 0);
    end
    chk("wide_halt", halt_signal, 1);
    chk("wide_spread", spread, 41);
    load(10, 20);
    for (int f = 0; f < 2; f++) begin
      idle(3);
      step(0, 480, 0, 0, 0, 0, 0);
      chk("frozen_tick", frame_tick, 0);
      chk("frozen_sell", sell_price, 141);
    end
    step(7, 30, 0, 0, 0, 0, 1);
    chk("resume_clears", halt_signal, 0);
    do_snap(0, 0);
    chk("reload_buy", buy_price, 10);
    chk("reload_spread", spread, 10);

    // Crossed book halts at once; streak clears on a frame at exactly the limit
    load(90, 80);
    do_snap(0, 0);
    chk("crossed_spread", spread, 0);
    chk("crossed_halt", halt_signal, 1);
    step(3, 40, 0, 0, 0, 0, 1);
    load(100, 141);
    do_snap(0, 0); do_snap(0, 0);
    load(100, 140);
    step(0, 480, 0, 0, 0, 0, 1);
    chk("resume_in_run_tick", frame_tick, 1);
    chk("limit_no_halt", halt_signal, 0);
    load(100, 141);
    do_snap(0, 0); do_snap(0, 0);
    chk("streak_cleared", halt_signal, 0);
    do_snap(0, 0);
    chk("streak_third", halt_signal, 1);

    // Asynchronous reset while halted and mid-frame
    idle(3);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_low_post_rst", u_if.upd_ready, 0);
    idle(1);
    load(30, 35);
    do_snap(0, 0);
    chk("post_rst_spread", spread, 5);

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      int h, v, b, s, uv, tp, res;
      if ($urandom_range(0, 24) == 0) begin
        h = 0; v = 480;
      end else begin
        h = $urandom_range(1, 799); v = $urandom_range(0, 524);
      end
      b = $urandom_range(0, 200);
      if ($urandom_range(0, 15) == 0) s = $urandom_range(0, 255);
      else s = b + $urandom_range(30, 55);
      uv  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      tp  = $urandom_range(0, 1);
      res = ($urandom_range(0, 40) == 0) ? 1 : 0;
      step(h, v, uv, b, s, tp, res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
